// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//   Writeback stage and architectural register file for a 5-stage pipeline.
//   It selects the writeback value from the MEM/WB outputs and commits it to
//   x1..x31. It serves two combinational ID-stage read ports with same-cycle
//   write-through bypass. It also counts committed register writes.
//
// Ports
//   clk_i       pipeline clock, rising-edge
//   rst_i       asynchronous, active-low reset
//   WB_i        register-write enable from MEM/WB
//   WBSrc_i     writeback source: 1 = MemRdata_i, 0 = ALUres_i
//   MemRdata_i  load data from MEM/WB
//   ALUres_i    ALU result from MEM/WB
//   rd_addr_i   destination register index
//   RS1addr_i   read port 1 index
//   RS2addr_i   read port 2 index
//   RS1data_o   read port 1 data (bypassed, zero for x0 and during reset)
//   RS2data_o   read port 2 data (bypassed, zero for x0 and during reset)
//   WBdata_o    selected writeback value, for the forwarding unit
//   WBcount_o   committed-write counter, wraps modulo 2^COUNT_WIDTH
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   WB_i,
  input  logic                   WBSrc_i,
  input  logic [DATA_WIDTH-1:0]  MemRdata_i,
  input  logic [DATA_WIDTH-1:0]  ALUres_i,
  input  logic [4:0]             rd_addr_i,
  input  logic [4:0]             RS1addr_i,
  input  logic [4:0]             RS2addr_i,
  output logic [DATA_WIDTH-1:0]  RS1data_o,
  output logic [DATA_WIDTH-1:0]  RS2data_o,
  output logic [DATA_WIDTH-1:0]  WBdata_o,
  output logic [COUNT_WIDTH-1:0] WBcount_o
);

  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   commit;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  // x0 has no storage. Only x1..x31 exist as flops.
  logic [DATA_WIDTH-1:0]  regs_q [1:31];

  assign wb_data  = WBSrc_i ? MemRdata_i : ALUres_i;
  assign WBdata_o = wb_data;

  // rst_i is included for clarity. The flops are held in reset anyway, so an
  // edge while reset is asserted can never commit.
  assign commit  = rst_i && WB_i && (rd_addr_i != 5'd0);
  assign count_d = count_q + COUNT_WIDTH'(1);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (commit && (rd_addr_i == i[4:0])) begin
          regs_q[i] <= wb_data;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (commit) begin
      count_q <= count_d;
    end
  end

  assign WBcount_o = count_q;

  // Plain array lookup written as a mux over x1..x31. Index 0 falls through to
  // zero, so the x0 case needs no out-of-range access.
  function automatic logic [DATA_WIDTH-1:0] rf_lookup(input logic [4:0] addr);
    rf_lookup = '0;
    for (int i = 1; i < 32; i++) begin
      if (addr == i[4:0]) begin
        rf_lookup = regs_q[i];
      end
    end
  endfunction

  // Both read ports share one structure. The bypass is gated by reset so that
  // the ports read zero for the whole reset window.
  logic [4:0]            rs_addr [2];
  logic [DATA_WIDTH-1:0] rs_data [2];

  assign rs_addr[0] = RS1addr_i;
  assign rs_addr[1] = RS2addr_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_rport
      assign rs_data[gi] = (!rst_i || (rs_addr[gi] == 5'd0)) ? '0 :
                           (WB_i && (rd_addr_i == rs_addr[gi])) ? wb_data :
                           rf_lookup(rs_addr[gi]);
    end
  endgenerate

  assign RS1data_o = rs_data[0];
  assign RS2data_o = rs_data[1];

endmodule

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
//   Self-checking bench for wb_regfile. Two instances share one stimulus
//   stream:
//     - dut uses the default 32-bit counter.
//     - dut_w uses a 4-bit counter, so the wrap behaviour is exercised.
//   The reference model is a plain array plus a counter. It is updated at each
//   commit edge and cleared on reset. A compare process checks every output
//   of both instances on every falling edge. Directed sections add literal
//   expectations.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb = 1'b0;
  logic        wbsrc = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] alu_res = '0;
  logic [4:0]  rd_addr = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;

  logic [31:0] rs1_data, rs2_data, wb_data, wb_count;
  logic [31:0] rs1_data_w, rs2_data_w, wb_data_w;
  logic [3:0]  wb_count_w;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: register contents and commit count.
  logic [31:0] model_rf [32] = '{default: '0};
  logic [31:0] model_cnt = '0;

  always #5 clk = ~clk;

  wb_regfile #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .WB_i(wb), .WBSrc_i(wbsrc),
    .MemRdata_i(mem_rdata), .ALUres_i(alu_res), .rd_addr_i(rd_addr),
    .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr),
    .RS1data_o(rs1_data), .RS2data_o(rs2_data),
    .WBdata_o(wb_data), .WBcount_o(wb_count)
  );

  wb_regfile #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut_w (
    .clk_i(clk), .rst_i(rst), .WB_i(wb), .WBSrc_i(wbsrc),
    .MemRdata_i(mem_rdata), .ALUres_i(alu_res), .rd_addr_i(rd_addr),
    .RS1addr_i(rs1_addr), .RS2addr_i(rs2_addr),
    .RS1data_o(rs1_data_w), .RS2data_o(rs2_data_w),
    .WBdata_o(wb_data_w), .WBcount_o(wb_count_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    return wbsrc ? mem_rdata : alu_res;
  endfunction

  function automatic logic [31:0] exp_rs(input logic [4:0] a);
    if (!rst || a == 5'd0) return 32'h0;
    if (wb && rd_addr == a) return exp_wb();
    return model_rf[a];
  endfunction

  // Reference model update: commit on a rising edge; clear immediately on reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) model_rf[i] = '0;
      model_cnt = '0;
    end else if (wb && rd_addr != 5'd0) begin
      model_rf[rd_addr] = exp_wb();
      model_cnt = model_cnt + 32'd1;
    end
  end

  // Compare process: checks every output of both instances on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wbdata", wb_data, exp_wb());
      chk("rs1", rs1_data, exp_rs(rs1_addr));
      chk("rs2", rs2_data, exp_rs(rs2_addr));
      chk("count", wb_count, model_cnt);
      chk("wbdata_w", wb_data_w, exp_wb());
      chk("rs1_w", rs1_data_w, exp_rs(rs1_addr));
      chk("rs2_w", rs2_data_w, exp_rs(rs2_addr));
      chk("count_w", {28'h0, wb_count_w}, {28'h0, model_cnt[3:0]});
    end
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic src, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] a1, input logic [4:0] a2);
    wb = w; wbsrc = src; rd_addr = rd; alu_res = alu; mem_rdata = mem;
    rs1_addr = a1; rs2_addr = a2;
  endtask

  initial begin
    // Reset state
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd31);
    #2;
    chk("reset_count", wb_count, 32'h0);
    chk("reset_rs1", rs1_data, 32'h0);
    chk("reset_rs2", rs2_data, 32'h0);
    step();
    rst = 1'b1;
    chk_en = 1'b1;

    // Reset clears a stored value immediately
    drive(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
    #1;
    chk("x5_stored", rs1_data, 32'hDEADBEEF);
    chk("count_one", wb_count, 32'd1);
    rst = 1'b0;
    #1;
    chk("midreset_rs1", rs1_data, 32'h0);
    chk("midreset_count", wb_count, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("x5_cleared", rs1_data, 32'h0);

    // Source select
    step();
    drive(1'b1, 1'b0, 5'd3, 32'h11, 32'h22, 5'd0, 5'd0);
    step();
    drive(1'b1, 1'b1, 5'd4, 32'h11, 32'h22, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd4);
    #1;
    chk("x3_alu", rs1_data, 32'h11);
    chk("x4_mem", rs2_data, 32'h22);
    chk("count_two", wb_count, 32'd2);

    // x0 protection
    drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd0);
    #1;
    chk("x0_rs1", rs1_data, 32'h0);
    chk("x0_wbdata", wb_data, 32'hFFFFFFFF);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    chk("x0_count", wb_count, 32'd2);

    // Bypass
    drive(1'b1, 1'b0, 5'd7, 32'h1, 32'h0, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);
    #1;
    chk("x7_stored", rs1_data, 32'h1);
    drive(1'b1, 1'b0, 5'd7, 32'h99, 32'h0, 5'd7, 5'd7);
    #1;
    chk("bypass_rs1", rs1_data, 32'h99);
    chk("bypass_rs2", rs2_data, 32'h99);
    step();
    chk("after_edge_rs1", rs1_data, 32'h99);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7);
    #1;
    chk("stored_rs1", rs1_data, 32'h99);
    chk("stored_rs2", rs2_data, 32'h99);
    chk("count_four", wb_count, 32'd4);

    // Counter wrap on the 4-bit instance: the count starts at 4, so 11
    // commits reach 15 and the 12th wraps to 0.
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 1'b0, 5'd1, k, 32'h0, 5'd1, 5'd2);
      step();
      if (k == 11) chk("wrap_15", {28'h0, wb_count_w}, 32'd15);
      if (k == 12) chk("wrap_0", {28'h0, wb_count_w}, 32'd0);
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd1, 5'd0);
    #1;
    chk("wrap_final", {28'h0, wb_count_w}, 32'd4);
    chk("count_20", wb_count, 32'd20);
    chk("x1_last_wins", rs1_data, 32'd16);

    // Random regression
    for (int n = 0; n < 10000; n++) begin
      logic [4:0] rd_r;
      rd_r = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd_r,
            $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? rd_r : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0) ? rd_r : 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 499) == 0) begin
        #1;
        rst = 1'b0;
        #1;
        chk("rand_reset_count", wb_count, 32'h0);
        chk("rand_reset_rs1", rs1_data, 32'h0);
        #1;
        rst = 1'b1;
      end
      step();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage register file for the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs (write enable, writeback-source select, memory read data, ALU result, destination address) and selects the writeback value. It commits that value to a 32-entry architectural register file and serves the two ID-stage read ports with same-cycle write-through bypass. It also exposes the selected writeback value for the forwarding unit and keeps a committed-write counter for debug and performance monitoring.

## Interface
- DATA_WIDTH, 32, register and datapath width
- COUNT_WIDTH, 32, width of the committed-write counter

- clk_i  input  1  pipeline clock; all state updates on the rising edge
- rst_i  input  1  asynchronous, active-low reset
- WB_i  input  1  register-write enable from MEM/WB
- WBSrc_i  input  1  writeback source: 1 = MemRdata_i, 0 = ALUres_i
- MemRdata_i  input  DATA_WIDTH  load data from MEM/WB
- ALUres_i  input  DATA_WIDTH  ALU result from MEM/WB
- rd_addr_i  input  5  destination register index
- RS1addr_i  input  5  read port 1 index (ID stage)
- RS2addr_i  input  5  read port 2 index (ID stage)
- RS1data_o  output  DATA_WIDTH  read port 1 data, bypassed
- RS2data_o  output  DATA_WIDTH  read port 2 data, bypassed
- WBdata_o  output  DATA_WIDTH  selected writeback value, for the forwarding unit
- WBcount_o  output  COUNT_WIDTH  number of committed register writes

## Operation
- Writeback select is combinational: WBdata_o = WBSrc_i ? MemRdata_i : ALUres_i. It is always driven, regardless of WB_i.
- A commit is a clock edge where rst_i=1, WB_i=1 and rd_addr_i != 0.
- On a commit, reg[rd_addr_i] <= WBdata_o and WBcount_o <= WBcount_o + 1.
- WBcount_o is modulo 2^COUNT_WIDTH: all-ones wraps to 0 with no saturation or flag.
- x0 is hardwired to zero and is not storage. Writes to index 0 are dropped and do not increment the counter.
- Read ports are combinational. For each port n:
  - if RSnaddr_i == 0, RSndata_o = 0
  - else if WB_i=1 and rd_addr_i == RSnaddr_i, RSndata_o = WBdata_o (write-through bypass)
  - else RSndata_o = reg[RSnaddr_i]
- Both ports may address the same register, including the bypassed one. Both then return identical data.
- While rst_i=0: RS1data_o = RS2data_o = 0 and bypass is disabled. WBdata_o still follows its select.
- No stall or flush inputs. Bubbles arrive from MEM/WB as WB_i=0.

## Timing
- Reset (asynchronous, rst_i low):
  - reg[1..31] = 0
  - WBcount_o = 0
  - RS1data_o = RS2data_o = 0
  - WBdata_o is combinational and not reset
- Reset mid-operation: the array and counter clear immediately on rst_i falling, without waiting for a clock edge. An edge while rst_i=0 commits nothing.
- The first commit is possible on the first rising edge after rst_i returns high.
- Write latency: the value is stored at the commit edge. It is visible through the array from that edge onward, and through the bypass in the same cycle before the edge.
- Read latency: 0 cycles (combinational from RSnaddr_i, WB_i, rd_addr_i, WBSrc_i and the data inputs).
- Counter: WBcount_o updates at the commit edge. It shows the new value one clock after WB_i was sampled high.
- Back-to-back commits to the same rd: the last one wins. Each commit increments the counter.
- A commit and a read of the same index in one cycle return the new value (bypass), never the stale one.

## Test plan
- Reset: write x5=0xDEADBEEF, then pulse rst_i low mid-cycle -> RS1data_o(x5)=0 immediately; WBcount_o=0.
- Source select: WB_i=1, rd=3, ALUres=0x11, MemRdata=0x22, WBSrc=0, then WBSrc=1 on rd=4 -> x3=0x11, x4=0x22, WBcount_o=2.
- x0 protection: WB_i=1, rd=0, ALUres=0xFFFFFFFF -> RS1data_o(x0)=0, WBcount_o unchanged, WBdata_o=0xFFFFFFFF.
- Bypass: x7 holds 0x1; in the same cycle WB_i=1, rd=7, ALUres=0x99, RS1=RS2=7 -> both ports return 0x99 before the edge and after it. With WB_i=0, the ports return the stored value.
- Counter wrap: COUNT_WIDTH=4, 16 commits to rd=1 -> WBcount_o goes 15 then 0.
- Random regression: 10k random WB_i/rd/src/data/read addresses against a reference model -> exact match on RS1data_o, RS2data_o, WBdata_o and WBcount_o every cycle.
